// File: rtl/apb_gpio_out_slave.sv
// APB3 slave holding a GPIO output register with SET/CLR/TGL aliases, a write counter and
// programmable wait states. Define APB_GPIO_OUT_LOCK_EN to add the write-lock register at 0x14.
module apb_gpio_out_slave #(
    parameter int unsigned WIDTH       = 32,
    parameter int unsigned WAIT_STATES = 0,
    parameter logic [31:0] RESET_VALUE = '0,
    parameter int unsigned ADDR_WIDTH  = 8
) (
    input  logic                  PCLK,
    input  logic                  PRESETN,
    input  logic                  PSEL,
    input  logic                  PENABLE,
    input  logic                  PWRITE,
    input  logic [ADDR_WIDTH-1:0] PADDR,
    input  logic [31:0]           PWDATA,
    output logic [31:0]           PRDATA,
    output logic                  PREADY,
    output logic                  PSLVERR,
    output logic [WIDTH-1:0]      GP_OUT
);

    typedef enum logic [0:0] {StIdle, StAccess} state_e;

    localparam logic [3:0]       WaitInit = 4'(WAIT_STATES);
    localparam logic [WIDTH-1:0] GpReset  = RESET_VALUE[WIDTH-1:0];
`ifdef APB_GPIO_OUT_LOCK_EN
    localparam logic [31:0]      MaxAddr  = 32'h14;
    localparam logic [31:0]      LockKey  = 32'h4C4F_434B;
`else
    localparam logic [31:0]      MaxAddr  = 32'h10;
`endif

    state_e                  state_q, state_d;
    logic [3:0]              cnt_q, cnt_d;
    logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
    logic                    write_q, write_d;
    logic [31:0]             wdata_q, wdata_d;
    logic [WIDTH-1:0]        gp_out_q, gp_out_d;
    logic [15:0]             wrcnt_q, wrcnt_d;
    logic                    lock_q, lock_d;

    logic [31:0]             addr_ext;
    logic [2:0]              reg_idx;
    logic                    acc_err;
    logic                    ready;
    logic                    complete;
    logic [31:0]             rd_value;
    logic [WIDTH-1:0]        wdata_w;
    logic                    unused_wdata;

    assign unused_wdata = ^wdata_q;
    assign wdata_w      = wdata_q[WIDTH-1:0];

    // Decode works entirely from the address/direction latched in the setup phase.
    always_comb begin
        addr_ext                   = '0;
        addr_ext[ADDR_WIDTH-1:0]   = addr_q;
        reg_idx                    = addr_ext[4:2];
        acc_err = (addr_ext[1:0] != 2'b00) || (addr_ext > MaxAddr) ||
                  (write_q && (reg_idx == 3'd4));
`ifdef APB_GPIO_OUT_LOCK_EN
        if (lock_q && write_q && (reg_idx <= 3'd3)) begin
            acc_err = 1'b1;
        end
`endif
        rd_value = '0;
        case (reg_idx)
            3'd0:    rd_value[WIDTH-1:0] = gp_out_q;
            3'd4:    rd_value[15:0]      = wrcnt_q;
            3'd5:    rd_value[0]         = lock_q;
            default: rd_value            = '0;
        endcase
    end

    assign ready   = (state_q == StAccess) && (cnt_q == 4'd0);
    assign PREADY  = ready;
    assign PSLVERR = ready && acc_err;
    assign PRDATA  = (ready && !write_q && !acc_err) ? rd_value : 32'd0;
    assign GP_OUT  = gp_out_q;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        addr_d   = addr_q;
        write_d  = write_q;
        wdata_d  = wdata_q;
        complete = 1'b0;
        case (state_q)
            StIdle: begin
                if (PSEL && !PENABLE) begin
                    state_d = StAccess;
                    cnt_d   = WaitInit;
                    addr_d  = PADDR;
                    write_d = PWRITE;
                    wdata_d = PWDATA;
                end
            end
            StAccess: begin
                // Dropping PSEL mid-transfer aborts it without committing anything.
                if (!PSEL) begin
                    state_d = StIdle;
                end else if (cnt_q != 4'd0) begin
                    cnt_d = cnt_q - 4'd1;
                end else if (PENABLE) begin
                    state_d  = StIdle;
                    complete = 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        gp_out_d = gp_out_q;
        wrcnt_d  = wrcnt_q;
        lock_d   = lock_q;
        if (complete && write_q && !acc_err) begin
            wrcnt_d = wrcnt_q + 16'd1;
            case (reg_idx)
                3'd0:    gp_out_d = wdata_w;
                3'd1:    gp_out_d = gp_out_q | wdata_w;
                3'd2:    gp_out_d = gp_out_q & ~wdata_w;
                3'd3:    gp_out_d = gp_out_q ^ wdata_w;
`ifdef APB_GPIO_OUT_LOCK_EN
                3'd5:    if (wdata_q == LockKey) lock_d = 1'b1;
`endif
                default: gp_out_d = gp_out_q;
            endcase
        end
`ifndef APB_GPIO_OUT_LOCK_EN
        lock_d = 1'b0;
`endif
    end

    always_ff @(posedge PCLK or negedge PRESETN) begin
        if (!PRESETN) begin
            state_q  <= StIdle;
            cnt_q    <= 4'd0;
            addr_q   <= '0;
            write_q  <= 1'b0;
            wdata_q  <= '0;
            gp_out_q <= GpReset;
            wrcnt_q  <= 16'd0;
            lock_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            addr_q   <= addr_d;
            write_q  <= write_d;
            wdata_q  <= wdata_d;
            gp_out_q <= gp_out_d;
            wrcnt_q  <= wrcnt_d;
            lock_q   <= lock_d;
        end
    end

endmodule
